vga_pattern_gen: RTL and testbench

Pixel-colour stage directly downstream of the VGA timing controller on the 25 MHz pixel clock. Consumes hsync/vsync/video_on and the active-pixel column number. Produces 4-bit-per-channel RGB test patterns, with hsync/vsync re-registered to stay aligned with the colour data. Pattern selection is frame-synchronous so the picture never tears.

---
 rtl/vga_pattern_gen.sv | 136 +++++++++++++
 tb/tb_vga_pattern_gen.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// Two-stage VGA test-pattern generator: colour bars, checkerboard, gradient, moving bar.
// Optional 1-pixel white border when VGA_PAT_BORDER_EN is defined.
module vga_pattern_gen #(
  parameter int unsigned HVID        = 640,
  parameter int unsigned VVID        = 480,
  parameter int unsigned BAR_W       = 80,
  parameter int unsigned CHECK_LOG2  = 5,
  parameter int unsigned SCROLL_STEP = 2
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       video_on_in,
  input  logic [9:0] pixel_x_in,
  input  logic [1:0] mode,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic [7:0] frame_cnt
);

  // Stage 1: registered copies of the timing inputs
  logic       hsync_s1_q, vsync_s1_q, video_on_s1_q;
  logic [9:0] pixel_x_s1_q;

  // Frame/line state
  logic [9:0] line_y_q, line_y_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [1:0] active_mode_q, active_mode_d;
  logic [9:0] bar_pos_q, bar_pos_d;

  // Stage 2: outputs
  logic        hsync_s2_q, vsync_s2_q;
  logic [11:0] rgb_q, rgb_d;

  logic        vs_rise, von_fall;
  logic [10:0] bar_sum;

  assign vs_rise  = vsync_in & ~vsync_s1_q;
  assign von_fall = video_on_s1_q & ~video_on_in;

  always_comb begin
    line_y_d      = line_y_q;
    frame_cnt_d   = frame_cnt_q;
    active_mode_d = active_mode_q;
    bar_pos_d     = bar_pos_q;
    bar_sum       = {1'b0, bar_pos_q} + 11'(SCROLL_STEP);
    if (vs_rise) begin
      line_y_d      = '0;
      frame_cnt_d   = frame_cnt_q + 8'd1;
      active_mode_d = mode;
      bar_pos_d     = (bar_sum >= 11'(HVID)) ? 10'd0 : bar_sum[9:0];
    end else if (von_fall && (line_y_q != 10'(VVID - 1))) begin
      line_y_d = line_y_q + 10'd1;
    end
  end

  logic [9:0]  bar_quot;
  logic [2:0]  bar_idx;
  logic [10:0] x_ext, bar_lo, bar_hi;
  logic [11:0] pat;

  always_comb begin
    bar_quot = pixel_x_s1_q / 10'(BAR_W);
    bar_idx  = (bar_quot > 10'd7) ? 3'd7 : bar_quot[2:0];
    x_ext    = {1'b0, pixel_x_s1_q};
    bar_lo   = {1'b0, bar_pos_q};
    // 11-bit compare so a bar near the right edge is clipped rather than wrapped
    bar_hi   = bar_lo + 11'(BAR_W);
    pat      = 12'h000;
    unique case (active_mode_q)
      2'd0: begin
        case (bar_idx)
          3'd0: pat = 12'hFFF;
          3'd1: pat = 12'hFF0;
          3'd2: pat = 12'h0FF;
          3'd3: pat = 12'h0F0;
          3'd4: pat = 12'hF0F;
          3'd5: pat = 12'hF00;
          3'd6: pat = 12'h00F;
          3'd7: pat = 12'h000;
        endcase
      end
      2'd1: pat = (pixel_x_s1_q[CHECK_LOG2] ^ line_y_q[CHECK_LOG2]) ? 12'h000 : 12'hFFF;
      2'd2: pat = {pixel_x_s1_q[9:6], line_y_q[8:5], frame_cnt_q[7:4]};
      2'd3: pat = ((x_ext >= bar_lo) && (x_ext < bar_hi)) ? 12'hFFF : 12'h000;
      default: pat = 12'h000;
    endcase
`ifdef VGA_PAT_BORDER_EN
    if ((pixel_x_s1_q == 10'd0) || (pixel_x_s1_q == 10'(HVID - 1)) ||
        (line_y_q == 10'd0) || (line_y_q == 10'(VVID - 1))) begin
      pat = 12'hFFF;
    end
`endif
    rgb_d = video_on_s1_q ? pat : 12'h000;
  end

  always_ff @(posedge clk_25) begin
    if (reset) begin
      hsync_s1_q    <= 1'b0;
      vsync_s1_q    <= 1'b0;
      video_on_s1_q <= 1'b0;
      pixel_x_s1_q  <= '0;
      line_y_q      <= '0;
      frame_cnt_q   <= '0;
      active_mode_q <= '0;
      bar_pos_q     <= '0;
      hsync_s2_q    <= 1'b0;
      vsync_s2_q    <= 1'b0;
      rgb_q         <= '0;
    end else begin
      hsync_s1_q    <= hsync_in;
      vsync_s1_q    <= vsync_in;
      video_on_s1_q <= video_on_in;
      pixel_x_s1_q  <= pixel_x_in;
      line_y_q      <= line_y_d;
      frame_cnt_q   <= frame_cnt_d;
      active_mode_q <= active_mode_d;
      bar_pos_q     <= bar_pos_d;
      hsync_s2_q    <= hsync_s1_q;
      vsync_s2_q    <= vsync_s1_q;
      rgb_q         <= rgb_d;
    end
  end

  assign hsync     = hsync_s2_q;
  assign vsync     = vsync_s2_q;
  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen; the border scenario runs only when
// VGA_PAT_BORDER_EN is defined.
module tb_vga_pattern_gen;

  localparam int HVID = 640;
  localparam int VVID = 480;
  localparam int BAR_W = 80;
  localparam int CHECK_LOG2 = 5;
  localparam int SCROLL_STEP = 2;

  logic       clk_25 = 1'b0;
  logic       reset = 1'b1;
  logic       hsync_in = 1'b0, vsync_in = 1'b0, video_on_in = 1'b0;
  logic [9:0] pixel_x_in = '0;
  logic [1:0] mode = '0;
  logic       hsync, vsync;
  logic [3:0] red, green, blue;
  logic [7:0] frame_cnt;

  vga_pattern_gen dut (
    .clk_25      (clk_25),
    .reset       (reset),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .video_on_in (video_on_in),
    .pixel_x_in  (pixel_x_in),
    .mode        (mode),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_cnt   (frame_cnt)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct {
    string       name;
    logic [13:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [13:0] obs_q[$];
  bit   [1:0]  ck;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model state
  int         m_line, m_bar;
  logic [7:0] m_frame;
  logic [1:0] m_mode;
  bit         m_vs, m_von;

  localparam logic [11:0] BAR_RGB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                          12'hF0F, 12'hF00, 12'h00F, 12'h000};

  function automatic logic [11:0] model_pat(input int x, input int y);
    logic [11:0] p;
    int idx;
    case (m_mode)
      2'd0: begin
        idx = x / BAR_W;
        if (idx > 7) idx = 7;
        p = BAR_RGB[idx];
      end
      2'd1: p = ((((x >> CHECK_LOG2) ^ (y >> CHECK_LOG2)) & 1) != 0) ? 12'h000 : 12'hFFF;
      2'd2: p = {4'((x >> 6) & 15), 4'((y >> 5) & 15), m_frame[7:4]};
      default: p = (x >= m_bar && x < m_bar + BAR_W) ? 12'hFFF : 12'h000;
    endcase
`ifdef VGA_PAT_BORDER_EN
    if (x == 0 || x == HVID - 1 || y == 0 || y == VVID - 1) p = 12'hFFF;
`endif
    return p;
  endfunction

  function automatic void model_reset();
    m_line = 0; m_bar = 0; m_frame = '0; m_mode = '0; m_vs = 0; m_von = 0;
  endfunction

  // One pixel clock: capture the output due from two cycles ago, drive, and
  // push the model's expectation when chk is set.
  task automatic cycle(input bit hs, input bit vs, input bit von, input int px,
                       input bit chk, input string nm);
    logic [11:0] rgb;
    @(negedge clk_25);
    if (ck[1]) obs_q.push_back({hsync, vsync, red, green, blue});
    ck[1] = ck[0];
    ck[0] = chk;
    hsync_in = hs; vsync_in = vs; video_on_in = von; pixel_x_in = 10'(px);
    if (vs && !m_vs) begin
      m_line  = 0;
      m_frame = m_frame + 8'd1;
      m_mode  = mode;
      m_bar   = (m_bar + SCROLL_STEP >= HVID) ? 0 : m_bar + SCROLL_STEP;
    end else if (m_von && !von && m_line < VVID - 1) begin
      m_line++;
    end
    m_vs = vs; m_von = von;
    rgb = von ? model_pat(px, m_line) : 12'h000;
    if (chk) exp_q.push_back('{nm, {hs, vs, rgb}});
  endtask

  task automatic pix(input int x, input string nm);
    cycle(0, 0, 1, x, 1, nm);
  endtask

  task automatic eol();
    cycle(1, 0, 0, 0, 0, "");
  endtask

  task automatic lines(input int n);
    repeat (n) begin
      cycle(0, 0, 1, 0, 0, "");
      eol();
    end
  endtask

  task automatic vsync_pulse();
    cycle(0, 1, 0, 0, 0, "");
    cycle(0, 0, 0, 0, 0, "");
  endtask

  task automatic flush();
    cycle(0, 0, 0, 0, 0, "");
    cycle(0, 0, 0, 0, 0, "");
  endtask

  task automatic apply_reset();
    @(negedge clk_25);
    reset = 1'b1;
    hsync_in = 0; vsync_in = 0; video_on_in = 0; pixel_x_in = '0;
    repeat (2) @(negedge clk_25);
    model_reset();
    ck = '0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [13:0] o;
    @(negedge clk_25);
    reset = 1'b1;
    hsync_in = 1; vsync_in = 1; video_on_in = 1; pixel_x_in = 10'd100; mode = 2'd2;
    repeat (3) @(negedge clk_25);
    n_cmp++;
    if ({hsync, vsync, red, green, blue} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_out: got %h want 0", {hsync, vsync, red, green, blue});
    end
    n_cmp++;
    if (frame_cnt !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_frame_cnt: got %h want 00", frame_cnt);
    end
    hsync_in = 0; vsync_in = 0; video_on_in = 0; pixel_x_in = '0; mode = 2'd0;
    model_reset();
    ck = '0;
    reset = 1'b0;
    repeat (4) cycle(0, 0, 0, 0, 1, "idle_after_reset");
    flush();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 14'hxxxx;
      n_cmp++;
      if (o !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.name, o, e.val);
      end
    end
    n_cmp++;
    if (frame_cnt !== 8'h00) begin
      n_bad++;
      $display("FAIL idle_frame_cnt: got %h want 00", frame_cnt);
    end
  endtask

  task automatic test_colour_bars();
    exp_t e;
    logic [13:0] o;
    mode = 2'd0;
    vsync_pulse();
    for (int x = 0; x < HVID; x++) pix(x, "colour_bars");
    eol();
    flush();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 14'hxxxx;
      n_cmp++;
      if (o !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_frame_sync_mode();
    exp_t e;
    logic [13:0] o;
    mode = 2'd0;
    vsync_pulse();
    lines(100);
    mode = 2'd1;
    pix(0, "mode_hold_x0");
    pix(80, "mode_hold_x80");
    pix(400, "mode_hold_x400");
    eol();
    lines(20);
    vsync_pulse();
    pix(0, "checker_y0_x0");
    pix(32, "checker_y0_x32");
    eol();
    lines(31);
    pix(0, "checker_y32_x0");
    pix(40, "checker_y32_x40");
    eol();
    flush();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 14'hxxxx;
      n_cmp++;
      if (o !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_blank_sync();
    exp_t e;
    logic [13:0] o;
    mode = 2'd2;
    repeat (2) cycle(0, 0, 0, 300, 1, "blank_pre");
    repeat (3) cycle(1, 0, 0, 300, 1, "blank_hsync");
    repeat (2) cycle(0, 0, 0, 300, 1, "blank_post");
    cycle(0, 1, 0, 300, 1, "blank_vsync");
    repeat (2) cycle(0, 0, 0, 300, 1, "blank_vs_post");
    flush();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 14'hxxxx;
      n_cmp++;
      if (o !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_moving_bar();
    exp_t e;
    logic [13:0] o;
    int guard;
    apply_reset();
    mode = 2'd3;
    repeat (3) begin
      vsync_pulse();
      if (m_bar > 0) pix(m_bar - 1, "bar_left_out");
      pix(m_bar, "bar_left_in");
      pix(m_bar + BAR_W - 1, "bar_right_in");
      pix(m_bar + BAR_W, "bar_right_out");
      eol();
    end
    guard = 0;
    while (m_bar != 638 && guard < 1000) begin vsync_pulse(); guard++; end
    pix(637, "bar638_x637");
    pix(638, "bar638_x638");
    pix(639, "bar638_x639");
    eol();
    vsync_pulse();
    pix(0, "bar_wrap_x0");
    pix(79, "bar_wrap_x79");
    pix(80, "bar_wrap_x80");
    eol();
    guard = 0;
    while (m_bar != 600 && guard < 1000) begin vsync_pulse(); guard++; end
    pix(599, "bar600_x599");
    pix(600, "bar600_x600");
    pix(639, "bar600_x639");
    pix(0, "bar600_x0");
    pix(39, "bar600_x39");
    eol();
    flush();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 14'hxxxx;
      n_cmp++;
      if (o !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_counters();
    exp_t e;
    logic [13:0] o;
    logic [7:0] f0;
    apply_reset();
    mode = 2'd2;
    vsync_pulse();
    lines(485);
    pix(100, "line_saturated");
    eol();
    pix(200, "line_still_saturated");
    eol();
    vsync_pulse();
    pix(100, "line_cleared");
    eol();
    flush();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 14'hxxxx;
      n_cmp++;
      if (o !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.name, o, e.val);
      end
    end
    f0 = m_frame;
    n_cmp++;
    if (frame_cnt !== f0) begin
      n_bad++;
      $display("FAIL frame_cnt_start: got %h want %h", frame_cnt, f0);
    end
    repeat (255) vsync_pulse();
    n_cmp++;
    if (frame_cnt !== 8'(f0 + 8'd255)) begin
      n_bad++;
      $display("FAIL frame_cnt_255: got %h want %h", frame_cnt, 8'(f0 + 8'd255));
    end
    vsync_pulse();
    n_cmp++;
    if (frame_cnt !== f0) begin
      n_bad++;
      $display("FAIL frame_cnt_wrap: got %h want %h", frame_cnt, f0);
    end
  endtask

`ifdef VGA_PAT_BORDER_EN
  task automatic test_border();
    exp_t e;
    logic [13:0] o;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      vsync_pulse();
      pix(0, "border_x0_y0");
      pix(300, "border_top");
      eol();
      lines(200);
      pix(0, "border_x0");
      pix(HVID - 1, "border_xmax");
      pix(300, "border_inner");
      eol();
      lines(300);
      pix(300, "border_ymax");
      eol();
    end
    flush();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 14'hxxxx;
      n_cmp++;
      if (o !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.name, o, e.val);
      end
    end
  endtask
`endif

  initial begin
    ck = '0;
    model_reset();
    test_reset();
    test_colour_bars();
    test_frame_sync_mode();
    test_blank_sync();
    test_moving_bar();
    test_counters();
`ifdef VGA_PAT_BORDER_EN
    test_border();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
